// File: rtl/stage_seq_pkg.sv
// Shared state encoding and fixed colours for the bomb-stage display sequencer.
package stage_seq_pkg;

    typedef enum logic [2:0] {
        SHOW     = 3'd0,
        WIPE     = 3'd1,
        FLASH    = 3'd2,
        EXPLODED = 3'd3,
        DEFUSED  = 3'd4
    } state_t;

    localparam logic [7:0] COLOR_RED   = 8'hE0;
    localparam logic [7:0] COLOR_GREEN = 8'h1C;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

endpackage

// File: rtl/stage_pixel_mux.sv
// Combinational colour path: picks the stage renderer, splits wipes, inverts
// for strike flashes, overrides terminal screens and blanks outside the visible area.
module stage_pixel_mux
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int H_VISIBLE  = 640,
    parameter int V_VISIBLE  = 480,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic [9:0]              hc,
    input  logic [9:0]              vc,
    input  logic [8*NUM_STAGES-1:0] stage_pixels,
    input  logic [SEL_W-1:0]        stage_sel,
    input  logic [10:0]             wipe_pos,
    input  logic                    in_wipe,
    input  logic                    invert,
    input  logic                    force_red,
    input  logic                    force_green,
    output logic [7:0]              pixel
);

    logic [SEL_W-1:0] sel;
    logic [7:0]       raw;
    logic             blank;

    // Blanking wins over everything, terminal colours win over stage pixels.
    always_comb begin
        sel = stage_sel;
        if (in_wipe && ({1'b0, hc} < wipe_pos)) begin
            sel = stage_sel + SEL_W'(1);
        end
        raw   = stage_pixels[{sel, 3'b000} +: 8];
        blank = (hc >= 10'(H_VISIBLE)) || (vc >= 10'(V_VISIBLE));

        pixel = invert ? ~raw : raw;
        if (force_red) begin
            pixel = COLOR_RED;
        end
        if (force_green) begin
            pixel = COLOR_GREEN;
        end
        if (blank) begin
            pixel = COLOR_BLACK;
        end
    end

endmodule

// File: rtl/stage_display_sequencer.sv
// Frame-synchronous sequencer choosing which bomb-stage renderer feeds the VGA
// colour path; game events are latched and only acted on at vertical blank.
module stage_display_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES    = 4,
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int WIPE_STEP     = 32,
    parameter int STRIKE_FRAMES = 8,
    parameter int MAX_STRIKES   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    hc,
    input  logic [9:0]                    vc,
    input  logic [8*NUM_STAGES-1:0]       stage_pixels,
    input  logic                          defuse_pulse,
    input  logic                          strike_pulse,
    output logic [7:0]                    pixel_out,
    output logic [$clog2(NUM_STAGES)-1:0] stage_sel,
    output logic [1:0]                    strikes,
    output logic                          frame_tick,
    output logic                          busy
);

    localparam int SEL_W = $clog2(NUM_STAGES);
    localparam int FC_W  = $clog2(STRIKE_FRAMES) + 1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] stage_sel_q, stage_sel_d;
    logic [1:0]       strikes_q, strikes_d, strikes_inc;
    logic [10:0]      wipe_pos_q, wipe_pos_d, wipe_next;
    logic [FC_W-1:0]  flash_cnt_q, flash_cnt_d, flash_next;
    logic             pend_def_q, pend_def_d;
    logic             pend_str_q, pend_str_d;
    logic             frame_tick_q;
    logic [7:0]       pixel_q, pixel_d;
    logic             boundary;

    assign boundary    = (hc == 10'd0) && (vc == 10'(V_VISIBLE));
    assign wipe_next   = wipe_pos_q + 11'(WIPE_STEP);
    assign flash_next  = flash_cnt_q + FC_W'(1);
    assign strikes_inc = (strikes_q == 2'(MAX_STRIKES)) ? strikes_q : strikes_q + 2'd1;

    // A pulse landing on the consuming boundary re-arms its flag rather than being lost.
    always_comb begin
        state_d     = state_q;
        stage_sel_d = stage_sel_q;
        strikes_d   = strikes_q;
        wipe_pos_d  = wipe_pos_q;
        flash_cnt_d = flash_cnt_q;
        pend_def_d  = pend_def_q | defuse_pulse;
        pend_str_d  = pend_str_q | strike_pulse;

        case (state_q)
            SHOW: begin
                if (boundary) begin
                    if (pend_str_q) begin
                        pend_str_d = strike_pulse;
                        strikes_d  = strikes_inc;
                        if (strikes_inc == 2'(MAX_STRIKES)) begin
                            state_d = EXPLODED;
                        end else begin
                            state_d     = FLASH;
                            flash_cnt_d = '0;
                        end
                    end else if (pend_def_q) begin
                        pend_def_d = defuse_pulse;
                        if (stage_sel_q == SEL_W'(NUM_STAGES - 1)) begin
                            state_d = DEFUSED;
                        end else begin
                            state_d    = WIPE;
                            wipe_pos_d = '0;
                        end
                    end
                end
            end
            WIPE: begin
                if (boundary) begin
                    if (wipe_next >= 11'(H_VISIBLE)) begin
                        state_d     = SHOW;
                        stage_sel_d = stage_sel_q + SEL_W'(1);
                        wipe_pos_d  = '0;
                    end else begin
                        wipe_pos_d = wipe_next;
                    end
                end
            end
            FLASH: begin
                if (boundary) begin
                    if (flash_next == FC_W'(STRIKE_FRAMES)) begin
                        state_d     = SHOW;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_next;
                    end
                end
            end
            EXPLODED, DEFUSED: begin
                pend_def_d = 1'b0;
                pend_str_d = 1'b0;
            end
            default: begin
                state_d = SHOW;
            end
        endcase
    end

    stage_pixel_mux #(
        .NUM_STAGES(NUM_STAGES),
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .SEL_W     (SEL_W)
    ) u_mux (
        .hc          (hc),
        .vc          (vc),
        .stage_pixels(stage_pixels),
        .stage_sel   (stage_sel_q),
        .wipe_pos    (wipe_pos_q),
        .in_wipe     (state_q == WIPE),
        .invert      ((state_q == FLASH) && !flash_cnt_q[0]),
        .force_red   (state_q == EXPLODED),
        .force_green (state_q == DEFUSED),
        .pixel       (pixel_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SHOW;
            stage_sel_q  <= '0;
            strikes_q    <= '0;
            wipe_pos_q   <= '0;
            flash_cnt_q  <= '0;
            pend_def_q   <= 1'b0;
            pend_str_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            pixel_q      <= COLOR_BLACK;
        end else begin
            state_q      <= state_d;
            stage_sel_q  <= stage_sel_d;
            strikes_q    <= strikes_d;
            wipe_pos_q   <= wipe_pos_d;
            flash_cnt_q  <= flash_cnt_d;
            pend_def_q   <= pend_def_d;
            pend_str_q   <= pend_str_d;
            frame_tick_q <= boundary;
            pixel_q      <= pixel_d;
        end
    end

    assign pixel_out  = pixel_q;
    assign stage_sel  = stage_sel_q;
    assign strikes    = strikes_q;
    assign frame_tick = frame_tick_q;
    assign busy       = (state_q == WIPE) || (state_q == FLASH);

endmodule

// File: tb/tb_stage_display_sequencer.sv
// Directed bench for stage_display_sequencer; hc/vc are driven directly so a
// "frame" is a handful of probe pixels followed by one boundary cycle.
module tb_stage_display_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic [31:0] stage_pixels;
    logic        defuse_pulse = 1'b0;
    logic        strike_pulse = 1'b0;
    logic [7:0]  pixel_out;
    logic [1:0]  stage_sel;
    logic [1:0]  strikes;
    logic        frame_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[8];

    stage_display_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .hc          (hc),
        .vc          (vc),
        .stage_pixels(stage_pixels),
        .defuse_pulse(defuse_pulse),
        .strike_pulse(strike_pulse),
        .pixel_out   (pixel_out),
        .stage_sel   (stage_sel),
        .strikes     (strikes),
        .frame_tick  (frame_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                                 input logic d, input logic s);
        hc = h;
        vc = v;
        defuse_pulse = d;
        strike_pulse = s;
        @(posedge clk);
        @(negedge clk);
        defuse_pulse = 1'b0;
        strike_pulse = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic boundary();
        applyStimulus(10'd0, 10'd480, 1'b0, 1'b0);
    endtask

    task automatic checkPixel(input string name, input logic [9:0] h, input logic [9:0] v,
                              input logic [7:0] exp);
        applyStimulus(h, v, 1'b0, 1'b0);
        checkOutput(name, pixel_out, exp);
    endtask

    initial begin
        stage_pixels = {8'h81, 8'hC3, 8'h03, 8'h5A};

        vecs[0] = '{10'd0,   10'd0,   8'h5A, "vis_origin"};
        vecs[1] = '{10'd320, 10'd240, 8'h5A, "vis_mid"};
        vecs[2] = '{10'd639, 10'd479, 8'h5A, "vis_corner"};
        vecs[3] = '{10'd640, 10'd0,   8'h00, "hblank_edge"};
        vecs[4] = '{10'd799, 10'd100, 8'h00, "hblank_end"};
        vecs[5] = '{10'd0,   10'd480, 8'h00, "vblank_edge"};
        vecs[6] = '{10'd100, 10'd524, 8'h00, "vblank_end"};
        vecs[7] = '{10'd639, 10'd0,   8'h5A, "vis_right"};

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_pixel",  pixel_out, 8'h00);
        checkOutput("rst_sel",    {6'd0, stage_sel}, 8'd0);
        checkOutput("rst_strikes",{6'd0, strikes}, 8'd0);
        checkOutput("rst_tick",   {7'd0, frame_tick}, 8'd0);
        checkOutput("rst_busy",   {7'd0, busy}, 8'd0);
        rst = 1'b0;

        // SHOW stage 0 table
        for (int i = 0; i < 8; i++) begin
            checkPixel(vecs[i].name, vecs[i].h, vecs[i].v, vecs[i].exp);
        end
        boundary();
        checkOutput("tick_on", {7'd0, frame_tick}, 8'd1);
        applyStimulus(10'd5, 10'd5, 1'b0, 1'b0);
        checkOutput("tick_off", {7'd0, frame_tick}, 8'd0);

        // Defuse -> wipe to stage 1
        applyStimulus(10'd100, 10'd100, 1'b1, 1'b0);
        checkOutput("def_no_busy", {7'd0, busy}, 8'd0);
        checkPixel("def_pre_px", 10'd5, 10'd5, 8'h5A);
        boundary();
        checkOutput("wipe_busy", {7'd0, busy}, 8'd1);
        checkPixel("wipe_f0", 10'd0, 10'd10, 8'h5A);
        boundary();
        checkPixel("wipe_f1_lo", 10'd0, 10'd10, 8'h03);
        checkPixel("wipe_f1_31", 10'd31, 10'd10, 8'h03);
        checkPixel("wipe_f1_32", 10'd32, 10'd10, 8'h5A);
        checkPixel("wipe_f1_hi", 10'd639, 10'd479, 8'h5A);
        repeat (18) boundary();
        checkOutput("wipe19_sel", {6'd0, stage_sel}, 8'd0);
        checkPixel("wipe19_600", 10'd600, 10'd0, 8'h03);
        checkPixel("wipe19_610", 10'd610, 10'd0, 8'h5A);
        boundary();
        checkOutput("wipe_done_sel", {6'd0, stage_sel}, 8'd1);
        checkOutput("wipe_done_busy", {7'd0, busy}, 8'd0);
        checkPixel("stage1_px", 10'd639, 10'd0, 8'h03);

        // Strike -> 8-frame flash
        applyStimulus(10'd10, 10'd10, 1'b0, 1'b1);
        checkOutput("str_pre_cnt", {6'd0, strikes}, 8'd0);
        boundary();
        checkOutput("str_cnt1", {6'd0, strikes}, 8'd1);
        for (int f = 0; f < 8; f++) begin
            checkOutput("flash_busy", {7'd0, busy}, 8'd1);
            checkPixel("flash_px", 10'd50, 10'd50, (f % 2 == 0) ? 8'hFC : 8'h03);
            boundary();
        end
        checkOutput("flash_end_busy", {7'd0, busy}, 8'd0);
        checkPixel("flash_end_px", 10'd50, 10'd50, 8'h03);

        // Simultaneous defuse+strike: flash first, wipe afterwards
        applyStimulus(10'd10, 10'd10, 1'b1, 1'b1);
        boundary();
        checkOutput("both_strikes", {6'd0, strikes}, 8'd2);
        checkPixel("both_flash_px", 10'd50, 10'd50, 8'hFC);
        repeat (8) boundary();
        checkOutput("both_show_busy", {7'd0, busy}, 8'd0);
        checkOutput("both_show_sel", {6'd0, stage_sel}, 8'd1);
        boundary();
        checkOutput("both_wipe_busy", {7'd0, busy}, 8'd1);
        repeat (20) boundary();
        checkOutput("both_wipe_sel", {6'd0, stage_sel}, 8'd2);
        checkPixel("stage2_px", 10'd200, 10'd200, 8'hC3);

        // Third strike explodes; later pulses ignored
        applyStimulus(10'd10, 10'd10, 1'b0, 1'b1);
        boundary();
        checkOutput("exp_strikes", {6'd0, strikes}, 8'd3);
        checkOutput("exp_busy", {7'd0, busy}, 8'd0);
        checkPixel("exp_px", 10'd300, 10'd300, 8'hE0);
        checkPixel("exp_blank", 10'd700, 10'd300, 8'h00);
        applyStimulus(10'd10, 10'd10, 1'b1, 1'b1);
        boundary();
        boundary();
        checkOutput("exp_ign_strikes", {6'd0, strikes}, 8'd3);
        checkOutput("exp_ign_sel", {6'd0, stage_sel}, 8'd2);
        checkPixel("exp_ign_px", 10'd0, 10'd0, 8'hE0);

        // Reset mid-wipe
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(10'd10, 10'd10, 1'b1, 1'b0);
        boundary();
        repeat (5) boundary();
        checkPixel("rw_px", 10'd100, 10'd10, 8'h03);
        #2 rst = 1'b1;
        #1;
        checkOutput("rw_async_px",   pixel_out, 8'h00);
        checkOutput("rw_async_busy", {7'd0, busy}, 8'd0);
        checkOutput("rw_async_sel",  {6'd0, stage_sel}, 8'd0);
        checkOutput("rw_async_str",  {6'd0, strikes}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        checkPixel("rw_after_px", 10'd100, 10'd10, 8'h5A);
        boundary();
        checkOutput("rw_after_busy", {7'd0, busy}, 8'd0);

        // Defuse through all stages
        for (int s = 0; s < 3; s++) begin
            applyStimulus(10'd10, 10'd10, 1'b1, 1'b0);
            boundary();
            repeat (20) boundary();
            checkOutput("chain_sel", {6'd0, stage_sel}, 8'(s + 1));
        end
        checkPixel("stage3_px", 10'd1, 10'd1, 8'h81);
        applyStimulus(10'd10, 10'd10, 1'b1, 1'b0);
        boundary();
        checkOutput("dfd_busy", {7'd0, busy}, 8'd0);
        checkPixel("dfd_px", 10'd400, 10'd400, 8'h1C);
        checkPixel("dfd_blank", 10'd400, 10'd500, 8'h00);
        applyStimulus(10'd10, 10'd10, 1'b0, 1'b1);
        boundary();
        checkOutput("dfd_ign_str", {6'd0, strikes}, 8'd0);
        checkPixel("dfd_ign_px", 10'd0, 10'd0, 8'h1C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
